// File: rtl/pwr_spec_pkg.sv
// Shared types and default sizes for the power-spectrum accumulator feeder.
package pwr_spec_pkg;

    localparam int unsigned DW_IN_DEF  = 25;
    localparam int unsigned DW_OUT_DEF = 50;
    localparam int unsigned POINTS_DEF = 8192;
    localparam int unsigned PT_W       = $clog2(POINTS_DEF);

    // Accumulation run sequencing states
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACCUM,
        FLUSH,
        DUMP
    } state_e;

endpackage

// File: rtl/pwr_spec_mag2.sv
// Two-stage |X|^2 pipeline: stage 1 squares re and im, stage 2 sums them.
// Ports: clk, rst_n; in_valid/re_i/im_i (signed sample); out_valid/out_mag
// (unsigned 2*DW_IN-bit magnitude, zero when out_valid is low).
module pwr_spec_mag2 #(
    parameter int unsigned DW_IN = 25
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [DW_IN-1:0]   re_i,
    input  logic signed [DW_IN-1:0]   im_i,
    output logic                      out_valid,
    output logic [2*DW_IN-1:0]        out_mag
);

    localparam int unsigned PW   = 2 * DW_IN;
    localparam int unsigned SQ_W = PW - 1;

    logic [SQ_W-1:0] re_sq_d, re_sq_q;
    logic [SQ_W-1:0] im_sq_d, im_sq_q;
    logic [PW-1:0]   mag_d, mag_q;
    logic            v1_q, v2_q;

    // A square of a DW_IN-bit signed value never exceeds 2^(2*DW_IN-2), so
    // SQ_W unsigned bits hold it; unaccepted samples are forced to zero.
    always_comb begin
        re_sq_d = in_valid ? SQ_W'(PW'(re_i) * PW'(re_i)) : '0;
        im_sq_d = in_valid ? SQ_W'(PW'(im_i) * PW'(im_i)) : '0;
        mag_d   = PW'(re_sq_q) + PW'(im_sq_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
            mag_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            mag_q   <= mag_d;
            v1_q    <= in_valid;
            v2_q    <= v1_q;
        end
    end

    assign out_valid = v2_q;
    assign out_mag   = mag_q;

endmodule

// File: rtl/pwr_spec_acc_ctrl.sv
// Feeds |X|^2 of FFT frames to the FIFO power-spectrum accumulator and
// sequences a multi-pulse accumulation run.
// Ports: acc_start/pls_num start a run; fft_re/fft_im/fft_valid/fft_sof carry
// frames; data_out/valid_out (valid leads data by VALID_LEAD) go to the
// accumulator; is_first_pls, Buffer_En, busy, done, frame_err report status.
module pwr_spec_acc_ctrl
    import pwr_spec_pkg::*;
#(
    parameter int unsigned DW_IN      = DW_IN_DEF,
    parameter int unsigned DW_OUT     = DW_OUT_DEF,
    parameter int unsigned POINTS     = POINTS_DEF,
    parameter int unsigned PLS_W      = 16,
    parameter int unsigned VALID_LEAD = 3,
    parameter int unsigned FLUSH_CYC  = 4,
    parameter int unsigned DUMP_CYC   = 8200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_start,
    input  logic [PLS_W-1:0]        pls_num,
    input  logic signed [DW_IN-1:0] fft_re,
    input  logic signed [DW_IN-1:0] fft_im,
    input  logic                    fft_valid,
    input  logic                    fft_sof,
    output logic [DW_OUT-1:0]       data_out,
    output logic                    valid_out,
    output logic                    is_first_pls,
    output logic                    Buffer_En,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_err
);

    localparam int unsigned PT_W_L    = $clog2(POINTS);
    localparam int unsigned WORD_LAT  = 2 + VALID_LEAD;
    // FLUSH spans the drain of the last word plus the idle gap
    localparam int unsigned FLUSH_TOT = WORD_LAT + FLUSH_CYC;
    localparam int unsigned SEQ_MAX   = (DUMP_CYC > FLUSH_TOT) ? DUMP_CYC : FLUSH_TOT;
    localparam int unsigned SEQ_W     = $clog2(SEQ_MAX + 1);
    localparam int unsigned FP_W      = $clog2(WORD_LAT + 1);

    state_e              state_d, state_q;
    logic [PT_W_L-1:0]   pt_cnt_d, pt_cnt_q;
    logic [PLS_W-1:0]    pls_cnt_d, pls_cnt_q;
    logic [PLS_W-1:0]    pls_tgt_d, pls_tgt_q;
    logic [SEQ_W-1:0]    seq_cnt_d, seq_cnt_q;
    logic [FP_W-1:0]     fp_cnt_d, fp_cnt_q;
    logic                is_first_d, is_first_q;
    logic                buf_en_d, buf_en_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                ferr_d, ferr_q;
    logic                accept_c;
    logic                mag_valid;
    logic [2*DW_IN-1:0]  mag_data;
    logic [DW_OUT-1:0]   dly_d [VALID_LEAD];
    logic [DW_OUT-1:0]   dly_q [VALID_LEAD];

    pwr_spec_mag2 #(.DW_IN(DW_IN)) u_mag2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_c),
        .re_i      (fft_re),
        .im_i      (fft_im),
        .out_valid (mag_valid),
        .out_mag   (mag_data)
    );

    // Next-state, counters and status flags
    always_comb begin
        state_d    = state_q;
        pt_cnt_d   = pt_cnt_q;
        pls_cnt_d  = pls_cnt_q;
        pls_tgt_d  = pls_tgt_q;
        seq_cnt_d  = seq_cnt_q;
        fp_cnt_d   = fp_cnt_q;
        is_first_d = is_first_q;
        buf_en_d   = buf_en_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        accept_c   = 1'b0;

        // is_first_pls falls once the last first-pulse word has left data_out
        if (fp_cnt_q != '0) begin
            fp_cnt_d = fp_cnt_q - FP_W'(1);
            if (fp_cnt_q == FP_W'(1)) begin
                is_first_d = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
                buf_en_d = 1'b0;
                if (acc_start) begin
                    pls_tgt_d  = (pls_num == '0) ? PLS_W'(1) : pls_num;
                    pls_cnt_d  = '0;
                    pt_cnt_d   = '0;
                    seq_cnt_d  = '0;
                    fp_cnt_d   = '0;
                    ferr_d     = 1'b0;
                    is_first_d = 1'b1;
                    buf_en_d   = 1'b1;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (fft_valid && fft_sof) begin
                    accept_c = 1'b1;
                    pt_cnt_d = PT_W_L'(1);
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (fft_valid) begin
                    if (fft_sof) begin
                        // sof always (re)starts a frame; mid-frame it flags an error
                        accept_c = 1'b1;
                        pt_cnt_d = PT_W_L'(1);
                        if (pt_cnt_q != '0) begin
                            ferr_d = 1'b1;
                        end
                    end else if (pt_cnt_q != '0) begin
                        accept_c = 1'b1;
                        if (pt_cnt_q == PT_W_L'(POINTS - 1)) begin
                            pt_cnt_d  = '0;
                            pls_cnt_d = pls_cnt_q + PLS_W'(1);
                            if (pls_cnt_q == '0) begin
                                fp_cnt_d = FP_W'(WORD_LAT);
                            end
                            if (pls_cnt_q + PLS_W'(1) == pls_tgt_q) begin
                                seq_cnt_d = '0;
                                state_d   = FLUSH;
                            end
                        end else begin
                            pt_cnt_d = pt_cnt_q + PT_W_L'(1);
                        end
                    end
                end
            end
            FLUSH: begin
                if (seq_cnt_q == SEQ_W'(FLUSH_TOT - 1)) begin
                    seq_cnt_d = '0;
                    buf_en_d  = 1'b0;
                    state_d   = DUMP;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            DUMP: begin
                buf_en_d = 1'b0;
                done_d   = (seq_cnt_q == SEQ_W'(DUMP_CYC - 2));
                if (seq_cnt_q == SEQ_W'(DUMP_CYC - 1)) begin
                    seq_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Data delay line: valid_out leads its data_out word by VALID_LEAD cycles
    always_comb begin
        dly_d[0] = DW_OUT'(mag_data);
        for (int i = 1; i < int'(VALID_LEAD); i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pt_cnt_q   <= '0;
            pls_cnt_q  <= '0;
            pls_tgt_q  <= '0;
            seq_cnt_q  <= '0;
            fp_cnt_q   <= '0;
            is_first_q <= 1'b0;
            buf_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            for (int i = 0; i < int'(VALID_LEAD); i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pt_cnt_q   <= pt_cnt_d;
            pls_cnt_q  <= pls_cnt_d;
            pls_tgt_q  <= pls_tgt_d;
            seq_cnt_q  <= seq_cnt_d;
            fp_cnt_q   <= fp_cnt_d;
            is_first_q <= is_first_d;
            buf_en_q   <= buf_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            for (int i = 0; i < int'(VALID_LEAD); i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign data_out     = dly_q[VALID_LEAD-1];
    assign valid_out    = mag_valid;
    assign is_first_pls = is_first_q;
    assign Buffer_En    = buf_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_pwr_spec_acc_ctrl.sv
// Randomized bench for pwr_spec_acc_ctrl with a timeline-based reference model.
module tb_pwr_spec_acc_ctrl;

    localparam int unsigned DW_IN      = 25;
    localparam int unsigned DW_OUT     = 50;
    localparam int unsigned POINTS     = 16;
    localparam int unsigned PLS_W      = 16;
    localparam int unsigned VALID_LEAD = 3;
    localparam int unsigned FLUSH_CYC  = 4;
    localparam int unsigned DUMP_CYC   = 24;
    localparam int          BIG        = 32'h3fff_ffff;
    localparam int          WORD_LAT   = 2 + int'(VALID_LEAD);
    localparam int          BUF_TAIL   = WORD_LAT + int'(FLUSH_CYC);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    acc_start = 1'b0;
    logic [PLS_W-1:0]        pls_num = '0;
    logic signed [DW_IN-1:0] fft_re = '0;
    logic signed [DW_IN-1:0] fft_im = '0;
    logic                    fft_valid = 1'b0;
    logic                    fft_sof = 1'b0;
    logic [DW_OUT-1:0]       data_out;
    logic                    valid_out, is_first_pls, Buffer_En, busy, done, frame_err;

    always #5 clk = ~clk;

    pwr_spec_acc_ctrl #(
        .DW_IN(DW_IN), .DW_OUT(DW_OUT), .POINTS(POINTS), .PLS_W(PLS_W),
        .VALID_LEAD(VALID_LEAD), .FLUSH_CYC(FLUSH_CYC), .DUMP_CYC(DUMP_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_start(acc_start), .pls_num(pls_num),
        .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid), .fft_sof(fft_sof),
        .data_out(data_out), .valid_out(valid_out), .is_first_pls(is_first_pls),
        .Buffer_En(Buffer_En), .busy(busy), .done(done), .frame_err(frame_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: a run is described by the cycle it started and the
    // cycles at which its phases end; words are scheduled into a timeline.
    int       run_start = -1;
    int       done_cyc = BIG, buf_end = BIG, fp_until = BIG;
    int       tgt = 0, pulses = 0, pos = 0;
    bit       armed = 0, collecting = 0, ferr_exp = 0;
    bit       exp_v [64];
    longint unsigned exp_d [64];
    int       lit_t1 = -100, lit_t2 = -100;
    int       cnt_v = 0, cnt_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned sq(input logic signed [DW_IN-1:0] x);
        longint v;
        v = longint'(x);
        return 64'(v * v);
    endfunction

    function automatic bit in_win(input int c, input int last);
        return (run_start >= 0) && (c > run_start) && (c <= last);
    endfunction

    task automatic model_clear();
        run_start = -1; done_cyc = BIG; buf_end = BIG; fp_until = BIG;
        tgt = 0; pulses = 0; pos = 0; armed = 0; collecting = 0; ferr_exp = 0;
        for (int i = 0; i < 64; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
    endtask

    task automatic model_step(input int k);
        bit acc;
        longint unsigned m;
        acc = 1'b0;
        m = '0;
        if (!in_win(k, done_cyc) && acc_start) begin
            run_start = k;
            tgt = (pls_num == '0) ? 1 : int'(pls_num);
            pulses = 0; pos = 0; armed = 1; collecting = 1; ferr_exp = 0;
            done_cyc = BIG; buf_end = BIG; fp_until = BIG;
        end else if (collecting && k > run_start && fft_valid) begin
            if (armed) begin
                if (fft_sof) begin acc = 1; armed = 0; pos = 1; end
            end else if (fft_sof) begin
                if (pos != 0) ferr_exp = 1;
                acc = 1; pos = 1;
            end else if (pos != 0) begin
                acc = 1;
                pos++;
                if (pos == int'(POINTS)) begin
                    pos = 0;
                    pulses++;
                    if (pulses == 1) fp_until = k + WORD_LAT;
                    if (pulses == tgt) begin
                        collecting = 0;
                        buf_end  = k + BUF_TAIL;
                        done_cyc = k + BUF_TAIL + int'(DUMP_CYC);
                    end
                end
            end
        end
        if (acc) m = sq(fft_re) + sq(fft_im);
        exp_v[(k + 2) % 64] = acc;
        exp_d[(k + WORD_LAT) % 64] = m;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) model_step(cyc);
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_out", 64'(valid_out), 64'(exp_v[cyc % 64]));
            chk("data_out", 64'(data_out), exp_d[cyc % 64]);
            chk("busy", 64'(busy), 64'(in_win(cyc, done_cyc)));
            chk("Buffer_En", 64'(Buffer_En), 64'(in_win(cyc, buf_end)));
            chk("is_first_pls", 64'(is_first_pls), 64'(in_win(cyc, fp_until)));
            chk("done", 64'(done), 64'(cyc == done_cyc));
            chk("frame_err", 64'(frame_err), 64'(ferr_exp));
            if (cyc == lit_t1 + 2) chk("lit_valid_t2", 64'(valid_out), 64'd1);
            if (cyc == lit_t1 + WORD_LAT) chk("lit_mag_25", 64'(data_out), 64'd25);
            if (cyc == lit_t2 + WORD_LAT) chk("lit_mag_max", 64'(data_out), 64'd1 << 49);
            if (valid_out) cnt_v++;
            if (done) cnt_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [DW_IN-1:0] rnd();
        return DW_IN'($urandom);
    endfunction

    task automatic drive_pt(input bit v, input bit s,
                            input logic signed [DW_IN-1:0] re,
                            input logic signed [DW_IN-1:0] im);
        fft_valid = v; fft_sof = s; fft_re = re; fft_im = im;
        tick();
    endtask

    task automatic idle_in();
        fft_valid = 1'b0; fft_sof = 1'b0;
    endtask

    // n points of a frame with random idle gaps; sof on the first if asked
    task automatic send_frame(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) drive_pt(1'b0, 1'($urandom_range(0, 1)), rnd(), rnd());
            drive_pt(1'b1, sof_first && (i == 0), rnd(), rnd());
        end
        idle_in();
    endtask

    // valid points without sof between frames, which must be dropped
    task automatic junk();
        repeat ($urandom_range(0, 3)) drive_pt(1'b1, 1'b0, rnd(), rnd());
        idle_in();
    endtask

    task automatic start_run(input int pls);
        cnt_v = 0; cnt_done = 0;
        pls_num = PLS_W'(pls);
        acc_start = 1'b1;
        chk("buf_en_before_start", 64'(Buffer_En), 64'd0);
        tick();
        acc_start = 1'b0;
        pls_num = PLS_W'($urandom);
        chk("buf_en_rise", 64'(Buffer_En), 64'd1);
        chk("first_in_arm", 64'(is_first_pls), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) chk("run_timeout", 64'(busy), 64'd0);
        repeat (3) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, 64'(data_out), 64'd0);
        chk({tag, "_valid_out"}, 64'(valid_out), 64'd0);
        chk({tag, "_is_first"}, 64'(is_first_pls), 64'd0);
        chk({tag, "_Buffer_En"}, 64'(Buffer_En), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        logic signed [DW_IN-1:0] minv;
        minv = {1'b1, {(DW_IN-1){1'b0}}};
        model_clear();
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Two clean frames; literal magnitudes at the head of frame 1
        start_run(2);
        drive_pt(1'b1, 1'b0, rnd(), rnd());
        drive_pt(1'b1, 1'b0, rnd(), rnd());
        lit_t1 = cyc;
        drive_pt(1'b1, 1'b1, 25'sd3, -25'sd4);
        lit_t2 = cyc;
        drive_pt(1'b1, 1'b0, minv, minv);
        send_frame(int'(POINTS) - 2, 1'b0);
        junk();
        send_frame(int'(POINTS), 1'b1);
        wait_done();
        chk("two_frame_words", 64'(cnt_v), 64'd32);
        chk("two_frame_done", 64'(cnt_done), 64'd1);

        // pls_num = 0 behaves as a single pulse
        start_run(0);
        junk();
        send_frame(int'(POINTS), 1'b1);
        wait_done();
        chk("pls0_words", 64'(cnt_v), 64'd16);
        chk("pls0_done", 64'(cnt_done), 64'd1);

        // sof after 7 points restarts the frame and flags an error
        start_run(1);
        send_frame(7, 1'b1);
        chk("ferr_before", 64'(frame_err), 64'd0);
        send_frame(int'(POINTS), 1'b1);
        chk("ferr_after", 64'(frame_err), 64'd1);
        wait_done();
        chk("ferr_words", 64'(cnt_v), 64'd23);
        chk("ferr_done", 64'(cnt_done), 64'd1);

        // acc_start while busy is ignored; new start clears frame_err
        start_run(1);
        chk("ferr_cleared", 64'(frame_err), 64'd0);
        send_frame(5, 1'b1);
        acc_start = 1'b1;
        pls_num = PLS_W'(7);
        drive_pt(1'b1, 1'b0, rnd(), rnd());
        acc_start = 1'b0;
        send_frame(int'(POINTS) - 6, 1'b0);
        wait_done();
        chk("busy_start_words", 64'(cnt_v), 64'd16);
        chk("busy_start_done", 64'(cnt_done), 64'd1);

        // Asynchronous reset mid-run aborts without a done pulse
        start_run(3);
        send_frame(int'(POINTS), 1'b1);
        send_frame(8, 1'b1);
        drive_pt(1'b1, 1'b0, rnd(), rnd());
        idle_in();
        cnt_done = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("reset_no_done", 64'(cnt_done), 64'd0);
        start_run(1);
        send_frame(int'(POINTS), 1'b1);
        wait_done();
        chk("post_reset_words", 64'(cnt_v), 64'd16);
        chk("post_reset_done", 64'(cnt_done), 64'd1);

        // Random runs with inter-frame junk and occasional framing errors
        for (int r = 0; r < 4; r++) begin
            int np;
            np = $urandom_range(1, 3);
            start_run(np);
            for (int f = 0; f < np; f++) begin
                junk();
                if ($urandom_range(0, 3) == 0) send_frame($urandom_range(1, int'(POINTS) - 1), 1'b1);
                send_frame(int'(POINTS), 1'b1);
            end
            wait_done();
            chk("rand_done", 64'(cnt_done), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwr_spec_acc_ctrl.md
Name: pwr_spec_acc_ctrl

Overview:
- Upstream feeder of the FIFO power-spectrum accumulator.
- Takes complex FFT output frames (one frame per laser pulse, 16 range gates x 512 bins) and forms |X|^2 = re^2 + im^2 as a 50-bit unsigned value.
- Emits each value with the early-valid timing the accumulator requires.
- Sequences accumulation over a programmable pulse count: drives is_first_pls during the first pulse, holds Buffer_En high while accumulating, then drops it for result readout.

Parameters:
- DW_IN, 25, signed width of fft_re/fft_im.
- DW_OUT, 50, width of |X|^2 (2*DW_IN, no overflow possible).
- POINTS, 8192, FFT points per pulse frame.
- PLS_W, 16, width of the pulse-count register.
- VALID_LEAD, 3, cycles by which valid_out precedes its data_out word.
- FLUSH_CYC, 4, idle cycles after the last data word before Buffer_En drops.
- DUMP_CYC, 8200, cycles Buffer_En is held low for readout (>= POINTS + FIFO read pipeline).

Ports:
- clk, in, 1, single system clock.
- rst_n, in, 1, asynchronous active-low reset.
- acc_start, in, 1, one-cycle request to start an accumulation run (honoured in IDLE only).
- pls_num, in, PLS_W, pulses to accumulate; sampled on accepted acc_start; 0 treated as 1.
- fft_re, in, DW_IN, signed real part.
- fft_im, in, DW_IN, signed imaginary part.
- fft_valid, in, 1, re/im valid this cycle.
- fft_sof, in, 1, first point of a frame; qualified by fft_valid.
- data_out, out, DW_OUT, |X|^2 to the accumulator.
- valid_out, out, 1, early valid to the accumulator.
- is_first_pls, out, 1, high for the whole first-pulse window.
- Buffer_En, out, 1, 1 = accumulate, 0 = read out results.
- busy, out, 1, state != IDLE.
- done, out, 1, one-cycle pulse when DUMP ends.
- frame_err, out, 1, sticky; set on a framing error; cleared by accepted acc_start.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately without a done pulse.
- Arithmetic:
  - Stage 1 registers re*re and im*im, each 2*DW_IN-1 bits, unsigned.
  - Stage 2 registers the sum zero-extended to DW_OUT.
  - Compute latency: 2 cycles from a fft_valid sample to the |X|^2 register.
- Output timing:
  - valid_out is asserted for the point sampled at cycle t, at cycle t+2.
  - data_out for that point is presented at cycle t+2+VALID_LEAD, held for one cycle.
  - Implement with a VALID_LEAD-deep data delay line; the valid path is not delayed.
  - In IDLE, ARM, FLUSH and DUMP, valid_out = 0.
- Counters:
  - pt_cnt, log2(POINTS) bits: 0..POINTS-1 within a frame.
  - pls_cnt, PLS_W bits: pulses completed.
- State machine:
  - IDLE: Buffer_En=0. acc_start latches pls_num, clears frame_err, goes to ARM.
  - ARM: Buffer_En=1, is_first_pls=1. Waits for fft_valid & fft_sof; that point is accepted and the state goes to ACCUM with pt_cnt=1.
  - ACCUM:
    - Every fft_valid point is forwarded and pt_cnt increments.
    - When the point with pt_cnt=POINTS-1 is accepted, pls_cnt increments and is_first_pls clears. The clear is delayed so it falls only after the last first-pulse data_out word.
    - If pls_cnt reaches the target, go to FLUSH. Otherwise wait for the next fft_sof in ACCUM; points without sof between frames are dropped.
  - FLUSH: counts FLUSH_CYC cycles after the last data_out word, then goes to DUMP.
  - DUMP: Buffer_En=0 for DUMP_CYC cycles. done pulses on the last cycle, then IDLE.
- Framing errors:
  - fft_sof inside a frame (pt_cnt != 0): set frame_err, restart the frame with this point as point 0. The partial frame's words are already sent; pls_cnt is not incremented.
  - In ARM, fft_valid without sof is ignored.
- acc_start while busy: ignored.
- pls_num = 1: is_first_pls covers the only pulse; the sequence still goes ACCUM to FLUSH to DUMP.
- Extreme values: re = im = -2^(DW_IN-1) gives 2^49, which must not overflow.

Decomposition:
- Package pwr_spec_pkg:
  - state enum {IDLE, ARM, ACCUM, FLUSH, DUMP}.
  - DW_IN/DW_OUT/POINTS defaults.
  - localparam PT_W = $clog2(POINTS).
- One sub-module: pwr_spec_mag2, the 2-stage registered re^2+im^2 pipeline with its valid bit.

Test Plan:
- Magnitude: re=3, im=-4 at cycle t -> valid_out at t+2, data_out=25 at t+5. Then re=im=-16777216 -> data_out=2^49 exactly.
- Run with pls_num=2, POINTS=16 (override), two clean frames:
  - Buffer_En rises on acc_start+1.
  - is_first_pls high for frame 1 words only.
  - 32 valid_out pulses.
  - Buffer_En falls FLUSH_CYC cycles after the last data_out word.
  - done pulses after DUMP_CYC cycles.
- pls_num=0 -> behaves as 1: 16 words, is_first_pls high throughout, single done.
- fft_sof injected at pt_cnt=7 in frame 1 -> frame_err=1, frame restarts, 16 further words still counted as pulse 1.
- acc_start pulsed during ACCUM -> no effect. Stray fft_valid without sof in ARM -> no valid_out.
- rst_n low during ACCUM -> all outputs 0 asynchronously, no done. A fresh acc_start then runs normally.
